// File: rtl/vdma_rd_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the VDMA read arbiter.
// A requester vector of up to 8 channels is supported by rr_pick.
package vdma_rd_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ADDR = 1'b1
    } state_t;

    localparam int OUTS_W = 4;
    localparam int RR_MAX = 8;
    localparam int RR_IW  = 3;

    // First requesting index searching upward from last+1 (mod num); returns last when nothing requests.
    function automatic logic [RR_IW-1:0] rr_pick(
        input logic [RR_MAX-1:0] req,
        input logic [RR_IW-1:0]  last,
        input int                num
    );
        logic [RR_IW-1:0] pick;
        logic             found;
        int               j;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= RR_MAX; i++) begin
            if (i <= num) begin
                j = (int'(last) + i) % num;
                if (!found && req[j]) begin
                    pick  = RR_IW'(j);
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index of the next requester after `last`.
// Purely combinational; the caller owns the last-grant register.
module rr_arbiter
    import vdma_rd_arb_pkg::*;
#(
    parameter int NUM = 4,
    parameter int IW  = $clog2(NUM)
) (
    input  logic [NUM-1:0] req,
    input  logic [IW-1:0]  last,
    output logic [NUM-1:0] gnt,
    output logic [IW-1:0]  idx
);

    logic [RR_IW-1:0] w_pick;
    logic             w_any;

    assign w_pick = rr_pick(RR_MAX'(req), RR_IW'(last), NUM);
    assign w_any  = |req;
    assign idx    = w_pick[IW-1:0];

    always_comb begin
        gnt = '0;
        for (int k = 0; k < NUM; k++) begin
            if (w_any && (w_pick == RR_IW'(k))) begin
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vdma_rd_arbiter.sv
// Shares one AXI4 read master between NUM VDMA read channels: round-robin AR issue,
// capped outstanding bursts, and R-beat routing back to the owner by axi_rid.
module vdma_rd_arbiter
    import vdma_rd_arb_pkg::*;
#(
    parameter int NUM      = 4,
    parameter int ASIZE    = 29,
    parameter int LSIZE    = 9,
    parameter int IDSIZE   = 4,
    parameter int ID_BASE  = 0,
    parameter int MAX_OUTS = 4
) (
    input  logic                   axi_aclk,
    input  logic                   axi_resetn,
    input  logic [NUM-1:0]         req_valid,
    input  logic [NUM*ASIZE-1:0]   req_addr,
    input  logic [NUM*LSIZE-1:0]   req_len,
    output logic [NUM-1:0]         req_ready,
    output logic [NUM-1:0]         req_done,
    input  logic [NUM-1:0]         ch_rready,
    output logic [NUM-1:0]         ch_rvalid,
    output logic [IDSIZE-1:0]      axi_arid,
    output logic [ASIZE-1:0]       axi_araddr,
    output logic [LSIZE-1:0]       axi_arlen,
    output logic                   axi_arvalid,
    input  logic                   axi_arready,
    input  logic [IDSIZE-1:0]      axi_rid,
    input  logic                   axi_rvalid,
    input  logic                   axi_rlast,
    output logic                   axi_rready,
    output logic [OUTS_W-1:0]      outstanding,
    output logic                   rid_err,
    output state_t                 dbg_state
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high;
    // valid never waits on ready, and AR payload is held stable while arvalid is high.

    localparam int                IW       = $clog2(NUM);
    localparam logic [OUTS_W-1:0] MAX_C    = OUTS_W'(MAX_OUTS);
    localparam logic [IW-1:0]     LAST_RST = IW'(NUM - 1);
    localparam logic [IDSIZE-1:0] BASE_C   = IDSIZE'(ID_BASE);
    localparam logic [IDSIZE:0]   NUM_C    = (IDSIZE + 1)'(NUM);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_last_grant;
    logic [IW-1:0]         w_win_idx;
    logic [NUM-1:0]        w_gnt;
    logic                  w_accept;
    logic                  w_ar_hs;

    logic [IDSIZE-1:0]     r_arid;
    logic [ASIZE-1:0]      r_araddr;
    logic [LSIZE-1:0]      r_arlen;
    logic [OUTS_W-1:0]     r_outs;
    logic [NUM-1:0]        r_done;
    logic                  r_rid_err;

    logic [IDSIZE-1:0]     w_r_idx;
    logic                  w_r_mapped;
    logic [NUM-1:0]        w_r_hit;
    logic                  w_rlast_hs;
    logic                  w_dec;
    logic                  w_underflow;

    rr_arbiter #(
        .NUM (NUM),
        .IW  (IW)
    ) u_rr (
        .req  (req_valid),
        .last (r_last_grant),
        .gnt  (w_gnt),
        .idx  (w_win_idx)
    );

    // Arbitration only happens in IDLE and only while there is room for another burst.
    assign w_accept = (r_state == IDLE) && (|req_valid) && (r_outs < MAX_C);
    assign w_ar_hs  = axi_arvalid && axi_arready;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ADDR;
            ADDR:    if (axi_arready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        axi_arvalid = (r_state == ADDR);
        req_ready   = w_accept ? w_gnt : '0;
        dbg_state   = r_state;
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_last_grant <= LAST_RST;
            r_arid       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_win_idx;
            r_arid       <= BASE_C + IDSIZE'(w_win_idx);
            r_araddr     <= req_addr[w_win_idx*ASIZE +: ASIZE];
            r_arlen      <= req_len[w_win_idx*LSIZE +: LSIZE];
        end
    end

    // R routing is purely combinational; unmapped IDs are drained with rready forced high.
    assign w_r_idx    = axi_rid - BASE_C;
    assign w_r_mapped = ({1'b0, w_r_idx} < NUM_C);

    always_comb begin
        ch_rvalid  = '0;
        axi_rready = 1'b1;
        w_r_hit    = '0;
        for (int k = 0; k < NUM; k++) begin
            if (w_r_mapped && (w_r_idx == IDSIZE'(k))) begin
                ch_rvalid[k] = axi_rvalid;
                axi_rready   = ch_rready[k];
                w_r_hit[k]   = 1'b1;
            end
        end
    end

    assign w_rlast_hs  = axi_rvalid && axi_rready && axi_rlast;
    assign w_dec       = w_rlast_hs && w_r_mapped && (r_outs != '0);
    assign w_underflow = w_rlast_hs && w_r_mapped && (r_outs == '0);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_outs    <= '0;
            r_done    <= '0;
            r_rid_err <= 1'b0;
        end else begin
            if (w_ar_hs && !w_dec) begin
                r_outs <= r_outs + 1'b1;
            end else if (!w_ar_hs && w_dec) begin
                r_outs <= r_outs - 1'b1;
            end
            r_done    <= w_rlast_hs ? w_r_hit : '0;
            r_rid_err <= r_rid_err | (axi_rvalid && !w_r_mapped) | w_underflow;
        end
    end

    assign axi_arid    = r_arid;
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_arlen;
    assign outstanding = r_outs;
    assign req_done    = r_done;
    assign rid_err     = r_rid_err;

endmodule

// File: tb/tb_vdma_rd_arbiter.sv
// Self-checking bench for vdma_rd_arbiter: directed scenarios plus a randomized run
// against a cycle-level behavioural reference model.
module tb_vdma_rd_arbiter;
  import vdma_rd_arb_pkg::*;

  localparam int NUM      = 4;
  localparam int ASIZE    = 29;
  localparam int LSIZE    = 9;
  localparam int IDSIZE   = 4;
  localparam int ID_BASE  = 0;
  localparam int MAX_OUTS = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM-1:0]       req_valid;
  logic [NUM*ASIZE-1:0] req_addr;
  logic [NUM*LSIZE-1:0] req_len;
  logic [NUM-1:0]       req_ready;
  logic [NUM-1:0]       req_done;
  logic [NUM-1:0]       ch_rready;
  logic [NUM-1:0]       ch_rvalid;
  logic [IDSIZE-1:0]    axi_arid;
  logic [ASIZE-1:0]     axi_araddr;
  logic [LSIZE-1:0]     axi_arlen;
  logic                 axi_arvalid;
  logic                 axi_arready;
  logic [IDSIZE-1:0]    axi_rid;
  logic                 axi_rvalid;
  logic                 axi_rlast;
  logic                 axi_rready;
  logic [3:0]           outstanding;
  logic                 rid_err;
  state_t               dbg_state;

  int checks = 0;
  int errors = 0;

  vdma_rd_arbiter #(
    .NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .IDSIZE(IDSIZE),
    .ID_BASE(ID_BASE), .MAX_OUTS(MAX_OUTS)
  ) dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .req_done(req_done),
    .ch_rready(ch_rready), .ch_rvalid(ch_rvalid),
    .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rid(axi_rid), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
    .axi_rready(axi_rready), .outstanding(outstanding), .rid_err(rid_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit               m_busy;
  int               m_last;
  int               m_outs;
  logic [IDSIZE-1:0] m_arid;
  logic [ASIZE-1:0] m_addr;
  logic [LSIZE-1:0] m_len;
  logic [NUM-1:0]   m_done;
  bit               m_err;

  bit               n_busy;
  int               n_last;
  int               n_outs;
  logic [IDSIZE-1:0] n_arid;
  logic [ASIZE-1:0] n_addr;
  logic [LSIZE-1:0] n_len;
  logic [NUM-1:0]   n_done;
  bit               n_err;

  logic [NUM-1:0]   e_ready;
  logic [NUM-1:0]   e_chv;
  logic             e_rready;

  task automatic model_reset();
    m_busy = 0; m_last = NUM - 1; m_outs = 0;
    m_arid = '0; m_addr = '0; m_len = '0; m_done = '0; m_err = 0;
  endtask

  // Expected combinational outputs for the current inputs, and the state after the next edge.
  task automatic model_eval();
    int win;
    int idx;
    bit mapped;
    bit last_hs;
    win = -1;
    e_ready = '0;
    if (!m_busy && req_valid != '0 && m_outs < MAX_OUTS) begin
      for (int i = 1; i <= NUM; i++) begin
        if (win < 0 && req_valid[(m_last + i) % NUM]) win = (m_last + i) % NUM;
      end
    end
    if (win >= 0) e_ready[win] = 1'b1;
    idx = int'(axi_rid) - ID_BASE;
    mapped = (idx >= 0) && (idx < NUM);
    e_rready = 1'b1;
    e_chv = '0;
    if (mapped) begin
      e_rready = ch_rready[idx];
      if (axi_rvalid) e_chv[idx] = 1'b1;
    end
    last_hs = axi_rvalid && e_rready && axi_rlast;
    n_outs = m_outs + ((m_busy && axi_arready) ? 1 : 0);
    if (mapped && last_hs && m_outs > 0) n_outs = n_outs - 1;
    n_err = m_err || (axi_rvalid && !mapped) || (mapped && last_hs && m_outs == 0);
    n_done = '0;
    if (mapped && last_hs) n_done[idx] = 1'b1;
    n_busy = m_busy && !axi_arready;
    n_last = m_last; n_arid = m_arid; n_addr = m_addr; n_len = m_len;
    if (win >= 0) begin
      n_busy = 1;
      n_last = win;
      n_arid = IDSIZE'(ID_BASE + win);
      n_addr = req_addr[win*ASIZE +: ASIZE];
      n_len  = req_len[win*LSIZE +: LSIZE];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic adv();
    model_eval();
    @(posedge clk);
    m_busy = n_busy; m_last = n_last; m_outs = n_outs; m_arid = n_arid;
    m_addr = n_addr; m_len = n_len; m_done = n_done; m_err = n_err;
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; ch_rready = '1;
    axi_arready = 1'b0; axi_rid = '0; axi_rvalid = 1'b0; axi_rlast = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (axi_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b exp 0", axi_arvalid); end
    checks++; if (axi_araddr !== '0) begin errors++; $display("FAIL reset_araddr: got %h exp 0", axi_araddr); end
    checks++; if (axi_arlen !== '0) begin errors++; $display("FAIL reset_arlen: got %h exp 0", axi_arlen); end
    checks++; if (axi_arid !== '0) begin errors++; $display("FAIL reset_arid: got %h exp 0", axi_arid); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d exp 0", outstanding); end
    checks++; if (req_done !== '0 || rid_err !== 1'b0) begin errors++; $display("FAIL reset_done_err: got %b/%b exp 0/0", req_done, rid_err); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp IDLE", dbg_state); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 4'b0100;
    req_addr[2*ASIZE +: ASIZE] = 29'h1000;
    req_len[2*LSIZE +: LSIZE] = 9'd255;
    axi_arready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready: got %b exp 0100", req_ready); end
    adv();
    req_valid = '0;
    #1;
    checks++; if (axi_arvalid !== 1'b1 || axi_arid !== 4'd2) begin errors++; $display("FAIL single_ar: got v=%b id=%0d exp v=1 id=2", axi_arvalid, axi_arid); end
    checks++; if (axi_araddr !== 29'h1000 || axi_arlen !== 9'd255) begin errors++; $display("FAIL single_ar_payload: got %h/%0d exp 1000/255", axi_araddr, axi_arlen); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_outs_pre: got %0d exp 0", outstanding); end
    adv();
    checks++; if (outstanding !== 4'd1 || axi_arvalid !== 1'b0) begin errors++; $display("FAIL single_outs_post: got %0d/%b exp 1/0", outstanding, axi_arvalid); end
    for (int i = 0; i < 256; i++) begin
      axi_rvalid = 1'b1; axi_rid = 4'd2; axi_rlast = (i == 255);
      #1;
      checks++; if (ch_rvalid !== 4'b0100 || axi_rready !== 1'b1) begin errors++; $display("FAIL single_beat%0d: got chv=%b rr=%b exp 0100/1", i, ch_rvalid, axi_rready); end
      if (i < 255) begin
        checks++; if (req_done !== '0) begin errors++; $display("FAIL single_early_done: got %b exp 0", req_done); end
      end
      adv();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    checks++; if (req_done !== 4'b0100 || outstanding !== 4'd0) begin errors++; $display("FAIL single_done: got %b/%0d exp 0100/0", req_done, outstanding); end
    adv();
    checks++; if (req_done !== '0) begin errors++; $display("FAIL single_done_pulse: got %b exp 0000", req_done); end
  endtask

  task automatic test_round_robin();
    logic [IDSIZE-1:0] exp_q[$];
    logic [IDSIZE-1:0] got_g[$];
    logic [IDSIZE-1:0] got_id[$];
    bit                pend;
    logic [IDSIZE-1:0] pend_id;
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
    apply_reset();
    req_valid = '1; axi_arready = 1'b1;
    for (int k = 0; k < NUM; k++) req_addr[k*ASIZE +: ASIZE] = ASIZE'(32'h100 * (k + 1));
    pend = 0;
    for (int c = 0; c < 60 && got_id.size() < 5; c++) begin
      #1;
      for (int k = 0; k < NUM; k++) if (req_ready[k]) got_g.push_back(IDSIZE'(k));
      pend = axi_arvalid && axi_arready;
      pend_id = axi_arid;
      if (pend) got_id.push_back(axi_arid);
      adv();
      axi_rvalid = pend; axi_rid = pend_id; axi_rlast = pend;
    end
    idle_inputs();
    checks++; if (got_id.size() != 5 || got_g.size() < 5) begin errors++; $display("FAIL rr_timeout: got %0d ARs %0d grants exp 5", got_id.size(), got_g.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < got_g.size() && i < got_id.size()) begin
        checks++; if (got_g[i] !== exp_q[i] || got_id[i] !== exp_q[i]) begin errors++; $display("FAIL rr_order%0d: got grant %0d arid %0d exp %0d", i, got_g[i], got_id[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_cap();
    int hs_cnt;
    int bad_ready;
    apply_reset();
    req_valid = 4'b0111; axi_arready = 1'b1;
    hs_cnt = 0; bad_ready = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (hs_cnt >= 2 && req_ready != '0) bad_ready++;
      if (axi_arvalid && axi_arready) hs_cnt++;
      adv();
    end
    checks++; if (hs_cnt != 2 || bad_ready != 0) begin errors++; $display("FAIL cap_issue: got %0d ARs %0d readies exp 2/0", hs_cnt, bad_ready); end
    checks++; if (outstanding !== 4'd2) begin errors++; $display("FAIL cap_outs: got %0d exp 2", outstanding); end
    axi_rvalid = 1'b1; axi_rid = 4'd0; axi_rlast = 1'b1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL cap_beat_ready: got %b exp 0000", req_ready); end
    adv();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd1 || req_ready !== 4'b0100) begin errors++; $display("FAIL cap_release: got %0d/%b exp 1/0100", outstanding, req_ready); end
    adv();
    req_valid = '0;
    #1;
    checks++; if (axi_arvalid !== 1'b1 || axi_arid !== 4'd2) begin errors++; $display("FAIL cap_third_ar: got v=%b id=%0d exp 1/2", axi_arvalid, axi_arid); end
  endtask

  task automatic test_arready_stall();
    logic [ASIZE-1:0] a;
    logic [LSIZE-1:0] l;
    a = ASIZE'($urandom());
    l = LSIZE'($urandom_range(0, 511));
    apply_reset();
    req_valid = 4'b0001;
    req_addr[0 +: ASIZE] = a; req_len[0 +: LSIZE] = l;
    adv();
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (axi_arvalid !== 1'b1 || axi_araddr !== a || axi_arlen !== l || axi_arid !== 4'd0) begin errors++; $display("FAIL stall_hold%0d: got %b %h %h %h exp 1 %h %h 0", c, axi_arvalid, axi_araddr, axi_arlen, axi_arid, a, l); end
      checks++; if (outstanding !== 4'd0 || req_ready !== '0) begin errors++; $display("FAIL stall_quiet%0d: got %0d/%b exp 0/0000", c, outstanding, req_ready); end
      adv();
    end
    axi_arready = 1'b1;
    adv();
    checks++; if (outstanding !== 4'd1 || axi_arvalid !== 1'b0) begin errors++; $display("FAIL stall_hs: got %0d/%b exp 1/0", outstanding, axi_arvalid); end
  endtask

  task automatic test_same_cycle();
    // Continues from test_arready_stall: one burst outstanding, channel 1 requesting.
    adv();
    req_valid = '0;
    axi_rvalid = 1'b1; axi_rid = 4'd0; axi_rlast = 1'b1;
    #1;
    checks++; if (axi_arvalid !== 1'b1 || outstanding !== 4'd1) begin errors++; $display("FAIL same_pre: got %b/%0d exp 1/1", axi_arvalid, outstanding); end
    adv();
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd1 || req_done !== 4'b0001) begin errors++; $display("FAIL same_cycle: got %0d/%b exp 1/0001", outstanding, req_done); end
  endtask

  task automatic test_unmapped();
    apply_reset();
    ch_rready = '0;
    axi_rvalid = 1'b1; axi_rid = 4'd7;
    #1;
    checks++; if (axi_rready !== 1'b1 || ch_rvalid !== '0) begin errors++; $display("FAIL unmapped_route: got rr=%b chv=%b exp 1/0000", axi_rready, ch_rvalid); end
    adv();
    axi_rvalid = 1'b0;
    #1;
    checks++; if (rid_err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b exp 1", rid_err); end
    req_valid = 4'b0001; req_addr[0 +: ASIZE] = 29'h1abc; req_len[0 +: LSIZE] = 9'd7;
    for (int c = 0; c < 3; c++) adv();
    req_valid = '0;
    #1;
    checks++; if (rid_err !== 1'b1 || axi_arvalid !== 1'b1) begin errors++; $display("FAIL unmapped_sticky: got err=%b v=%b exp 1/1", rid_err, axi_arvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rid_err !== 1'b0 || axi_arvalid !== 1'b0 || outstanding !== 4'd0) begin errors++; $display("FAIL async_reset: got err=%b v=%b outs=%0d exp 0/0/0", rid_err, axi_arvalid, outstanding); end
    checks++; if (axi_araddr !== '0 || axi_arlen !== '0 || axi_arid !== '0 || req_done !== '0 || req_ready !== '0) begin errors++; $display("FAIL async_reset_ar: got %h %h %h %b %b exp all 0", axi_araddr, axi_arlen, axi_arid, req_done, req_ready); end
    apply_reset();
  endtask

  task automatic test_random();
    logic [NUM-1:0] held;
    logic [NUM-1:0] acc;
    apply_reset();
    held = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NUM; k++) begin
        if (!held[k] && $urandom_range(0, 2) == 0) begin
          held[k] = 1'b1;
          req_addr[k*ASIZE +: ASIZE] = ASIZE'($urandom());
          req_len[k*LSIZE +: LSIZE] = LSIZE'($urandom());
        end
      end
      req_valid   = held;
      axi_arready = ($urandom_range(0, 2) != 0);
      axi_rvalid  = $urandom_range(0, 1);
      axi_rid     = ($urandom_range(0, 19) == 0) ? IDSIZE'($urandom_range(4, 15)) : IDSIZE'($urandom_range(0, 3));
      axi_rlast   = ($urandom_range(0, 3) == 0);
      ch_rready   = NUM'($urandom());
      model_eval();
      #1;
      checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, req_ready, e_ready); end
      checks++; if (axi_arvalid !== m_busy) begin errors++; $display("FAIL rnd_arvalid c%0d: got %b exp %b", c, axi_arvalid, m_busy); end
      checks++; if (axi_arid !== m_arid || axi_araddr !== m_addr || axi_arlen !== m_len) begin errors++; $display("FAIL rnd_ar c%0d: got %h %h %h exp %h %h %h", c, axi_arid, axi_araddr, axi_arlen, m_arid, m_addr, m_len); end
      checks++; if (outstanding !== 4'(m_outs)) begin errors++; $display("FAIL rnd_outs c%0d: got %0d exp %0d", c, outstanding, m_outs); end
      checks++; if (req_done !== m_done || rid_err !== m_err) begin errors++; $display("FAIL rnd_done_err c%0d: got %b/%b exp %b/%b", c, req_done, rid_err, m_done, m_err); end
      checks++; if (ch_rvalid !== e_chv || axi_rready !== e_rready) begin errors++; $display("FAIL rnd_route c%0d: got %b/%b exp %b/%b", c, ch_rvalid, axi_rready, e_chv, e_rready); end
      acc = e_ready;
      adv();
      held = held & ~acc;
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_cap();
    test_arready_stall();
    test_same_cycle();
    test_unmapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
